// File: rtl/bitop_unit_if.sv
// bitop_unit_if: start/busy/done bus for bitop_unit.
// master drives start/op/a/b; slave returns busy/done/res/illegal.
interface bitop_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, res, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, res, illegal
  );
endinterface

// File: rtl/bitop_unit.sv
// bitop_unit: multi-cycle bitwise unit, one SLICE per clock, LSB first.
// Ports: clk, rst_n (async low), bus (slave). Macro BITOP_POPCNT_EN adds POPCNT.
module bitop_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  bitop_unit_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;

  localparam logic [WIDTH-1:0] MASK =
    WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nx;
  logic             ill_q;
  logic             accept;
  logic             last;
  logic             bad_op;
  logic [31:0]      sh;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sv;

  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));
  assign sa     = a_q[SLICE-1:0];
  assign sb     = b_q[SLICE-1:0];

`ifdef BITOP_POPCNT_EN
  localparam int AW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_POP = 3'b110;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nx;

  function automatic logic [AW-1:0] ones(
    input logic [SLICE-1:0] v
  );
    logic [AW-1:0] c;
    c = '0;
    for (int i = 0; i < SLICE; i++)
      c = c + AW'(v[i]);
    return c;
  endfunction

  assign acc_nx = acc + ones(sa ^ sb);
  assign bad_op = (op_q == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (accept)
      acc <= '0;
    else if (state == RUN && op_q == OP_POP)
      acc <= acc_nx;
  end
`else
  assign bad_op = (op_q[2:1] == 2'b11);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_comb begin
    unique case (1'b1)
      op_q == OP_AND:  sv = sa & sb;
      op_q == OP_OR:   sv = sa | sb;
      op_q == OP_XOR:  sv = sa ^ sb;
      op_q == OP_NOR:  sv = ~(sa | sb);
      op_q == OP_XNOR: sv = ~(sa ^ sb);
      op_q == OP_ANDN: sv = sa & ~sb;
      default:         sv = '0;
    endcase
  end

  // Operands shift down each cycle, so slice k is
  // always at the bottom; the result slot moves up.
  always_comb begin
    sh     = 32'(cnt) * 32'(SLICE);
    res_nx = (res_q & ~(MASK << sh))
           | (WIDTH'(sv) << sh);
`ifdef BITOP_POPCNT_EN
    if (op_q == OP_POP)
      res_nx = WIDTH'(acc_nx);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      op_q  <= bus.op;
      cnt   <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (state == RUN) begin
      a_q   <= a_q >> SLICE;
      b_q   <= b_q >> SLICE;
      res_q <= res_nx;
      if (last) begin
        cnt   <= '0;
        ill_q <= bad_op;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.res     = res_q;
  assign bus.illegal = ill_q;
endmodule

// File: tb/tb_bitop_unit.sv
// tb_bitop_unit: directed + random checks of bitop_unit
// against a whole-word reference model.
module tb_bitop_unit;
  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitop_unit_if #(.WIDTH(W)) bus ();

  bitop_unit #(
    .WIDTH(W),
    .SLICE(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic model(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        il
  );
    il = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: r = ~(a ^ b);
      3'd5: r = a & ~b;
`ifdef BITOP_POPCNT_EN
      3'd6: r = 32'($countones(a ^ b));
`else
      3'd6: begin r = 0; il = 1'b1; end
`endif
      default: begin r = 0; il = 1'b1; end
    endcase
  endtask

  logic [31:0] last_res;

  // Called at a negedge in IDLE or DONE; returns at
  // the negedge of the done cycle with start low.
  task automatic do_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          hold
  );
    logic [31:0] er;
    logic        ei;
    model(op, a, b, er, ei);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    check("accept_clr_ill", bus.illegal, 0);
    for (int i = 0; i < N; i++) begin
      check("busy", bus.busy, 1);
      check("done_early", bus.done, 0);
      if (hold && i < N - 1) begin
        bus.op = 3'($urandom);
        bus.a  = $urandom;
        bus.b  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("done", bus.done, 1);
    check("busy_in_done", bus.busy, 0);
    check("res", bus.res, er);
    check("illegal", bus.illegal, ei);
    last_res = er;
  endtask

  task automatic idle_check();
    logic ill;
    ill = bus.illegal;
    @(negedge clk);
    check("done_pulse_1", bus.done, 0);
    check("res_hold", bus.res, last_res);
    check("ill_hold", bus.illegal, ill);
  endtask

  initial begin
    int unsigned t0;
    bit          seen;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    last_res  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res", bus.res, 0);
    check("rst_ill", bus.illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    check("xor_vec", bus.res, 32'hFF00_EDCB);
    idle_check();
    do_op(3'd3, 32'h0, 32'h0, 0);
    check("nor_vec", bus.res, 32'hFFFF_FFFF);
    do_op(3'd5, 32'hFFFF_FFFF, 32'h0000_FFFF, 0);
    check("andn_vec", bus.res, 32'hFFFF_0000);
    do_op(3'd4, 32'h1234_5678, 32'h1234_5678, 0);
    check("xnor_vec", bus.res, 32'hFFFF_FFFF);
    idle_check();

    do_op(3'd6, 32'hFFFF_FFFF, 32'h0, 0);
    do_op(3'd6, 32'h8000_0001, 32'h0, 0);
    idle_check();

    do_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("ill_vec", bus.illegal, 1);
    idle_check();
    do_op(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    check("and_after_ill", bus.res, 32'hF000_F000);

    do_op(3'd1, 32'h0000_1111, 32'h2222_0000, 1);
    check("hold_ignored", bus.res, 32'h2222_1111);
    idle_check();

    do_op(3'd1, 32'h1, 32'h2, 0);
    t0 = cyc;
    do_op(3'd2, 32'hAAAA_5555, 32'hFFFF_0000, 0);
    check("b2b_gap", cyc - t0, 5);
    idle_check();

    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_res", bus.res, 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    check("no_done_abort", seen, 0);
    do_op(3'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 0);
    check("and_post_rst", bus.res, 32'h0F00_0F00);

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = 32'h0;
      do_op(op, a, b, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) idle_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
